// File: rtl/rst_seq_if.sv
// Request/status bundle between the core-side reset sequencer and its clients.
// The slave side (the sequencer) takes requests and drives the domain resets and status.
interface rst_seq_if #(
    parameter int N_DOM = 3,
    parameter int WDT_W = 16
);
    logic             sw_rst_req;
    logic             wdt_en;
    logic             wdt_kick;
    logic [WDT_W-1:0] wdt_load;
    logic [N_DOM-1:0] dom_rst_n;
    logic             rst_done;
    logic             busy;
    logic [1:0]       rst_cause;

    modport master (
        output sw_rst_req, wdt_en, wdt_kick, wdt_load,
        input  dom_rst_n, rst_done, busy, rst_cause
    );

    modport slave (
        input  sw_rst_req, wdt_en, wdt_kick, wdt_load,
        output dom_rst_n, rst_done, busy, rst_cause
    );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains, releases them in index order, and raises internal
// resets from software or watchdog. Optional macro RST_SEQ_CAUSE_STICKY_EN keeps rst_cause across int_rst.
module rst_seq #(
    parameter int N_DOM     = 3,
    parameter int PULSE_CYC = 32,
    parameter int STAGE_CYC = 16,
    parameter int WDT_W     = 16
) (
    input  logic   clk,
    input  logic   int_rst,
    rst_seq_if.slave bus
);
    localparam int MAXC  = (PULSE_CYC > STAGE_CYC) ? PULSE_CYC : STAGE_CYC;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IDX_W = $clog2(N_DOM + 1);

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic             done_q, done_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [1:0]       cause_d;

`ifdef RST_SEQ_CAUSE_STICKY_EN
    // Power-up value only; int_rst leaves the last cause readable by software.
    logic [1:0] cause_q = CAUSE_EXT;
    always_ff @(posedge clk) begin
        cause_q <= cause_d;
    end
`else
    logic [1:0] cause_q;
    always_ff @(posedge clk or negedge int_rst) begin
        if (!int_rst) cause_q <= CAUSE_EXT;
        else          cause_q <= cause_d;
    end
`endif

    logic wdt_expire;
    assign wdt_expire = bus.wdt_en && !bus.wdt_kick && (wdt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        wdt_d   = bus.wdt_load;
        cause_d = cause_q;
        unique case (state_q)
            HOLD: begin
                if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(STAGE_CYC - 1)) begin
                    for (int k = 0; k < N_DOM; k++) begin
                        if (idx_q == IDX_W'(k)) dom_d[k] = 1'b1;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = '0;
                    if (idx_q == IDX_W'(N_DOM - 1)) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (bus.wdt_en && !bus.wdt_kick) wdt_d = wdt_q - WDT_W'(1);
                // Software beats the watchdog when both fire on one edge.
                if (bus.sw_rst_req || wdt_expire) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                    done_d  = 1'b0;
                    wdt_d   = bus.wdt_load;
                    cause_d = bus.sw_rst_req ? CAUSE_SW : CAUSE_WDT;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                dom_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    // wdt_q is reloaded on every HOLD/RELEASE edge, so its reset value never reaches RUN.
    always_ff @(posedge clk or negedge int_rst) begin
        if (!int_rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            wdt_q   <= wdt_d;
        end
    end

    assign bus.dom_rst_n = dom_q;
    assign bus.rst_done  = done_q;
    assign bus.busy      = (state_q != RUN);
    assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_rst_seq.sv
// Scenario bench for rst_seq: expected per-edge status is queued when stimulus is applied
// and popped after the edge to compare against the DUT.
module tb_rst_seq;
    localparam int N_DOM     = 3;
    localparam int PULSE_CYC = 32;
    localparam int STAGE_CYC = 16;
    localparam int WDT_W     = 16;
    localparam int SEQ_LEN   = PULSE_CYC + N_DOM * STAGE_CYC;

    typedef struct {
        int               e;
        logic [N_DOM-1:0] dom;
        logic             done;
        logic             busy;
        logic [1:0]       cause;
    } exp_t;

    logic clk = 1'b0;
    logic int_rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    rst_seq_if #(.N_DOM(N_DOM), .WDT_W(WDT_W)) bus ();

    rst_seq #(
        .N_DOM(N_DOM), .PULSE_CYC(PULSE_CYC), .STAGE_CYC(STAGE_CYC), .WDT_W(WDT_W)
    ) dut (
        .clk(clk),
        .int_rst(int_rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int e, input logic [1:0] cause);
        exp_t x;
        x.e = e;
        x.dom = '0;
        for (int k = 0; k < N_DOM; k++)
            if (e >= PULSE_CYC + (k + 1) * STAGE_CYC) x.dom[k] = 1'b1;
        x.done  = (e >= SEQ_LEN);
        x.busy  = !x.done;
        x.cause = cause;
        return x;
    endfunction

    // Walks edges 1..last_e of a release sequence; optionally pulses sw_rst_req on one edge.
    task automatic run_seq(input int last_e, input logic [1:0] cause, input int sw_e);
        exp_t x;
        for (int e = 1; e <= last_e; e++) begin
            bus.sw_rst_req = (e == sw_e);
            sb.push_back(model(e, cause));
            tick();
            x = sb.pop_front();
            n_cmp++;
            if (bus.dom_rst_n !== x.dom || bus.rst_done !== x.done ||
                bus.busy !== x.busy || bus.rst_cause !== x.cause) begin
                n_err++;
                $display("FAIL seq_edge%0d: dom=%b done=%b busy=%b cause=%b, want dom=%b done=%b busy=%b cause=%b",
                         x.e, bus.dom_rst_n, bus.rst_done, bus.busy, bus.rst_cause,
                         x.dom, x.done, x.busy, x.cause);
            end
        end
        bus.sw_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (5) tick();
        n_cmp++;
        if (bus.dom_rst_n !== '0 || bus.rst_done !== 1'b0 || bus.busy !== 1'b1 || bus.rst_cause !== 2'b00) begin
            n_err++;
            $display("FAIL reset: dom=%b done=%b busy=%b cause=%b, want 000/0/1/00",
                     bus.dom_rst_n, bus.rst_done, bus.busy, bus.rst_cause);
        end
    endtask

    task automatic test_power_on();
        int_rst = 1'b1;
        run_seq(SEQ_LEN, 2'b00, -1);
    endtask

    task automatic test_sw_reset();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        n_cmp++;
        if (bus.dom_rst_n !== '0 || bus.rst_done !== 1'b0 || bus.busy !== 1'b1 || bus.rst_cause !== 2'b01) begin
            n_err++;
            $display("FAIL sw_entry: dom=%b done=%b busy=%b cause=%b, want 000/0/1/01",
                     bus.dom_rst_n, bus.rst_done, bus.busy, bus.rst_cause);
        end
        run_seq(SEQ_LEN, 2'b01, -1);
    endtask

    task automatic test_wdt_expiry();
        bus.wdt_load = 16'd10;
        bus.wdt_en   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL wdt_early_edge%0d: busy=%b, want 0", i, bus.busy);
            end
        end
        tick();
        bus.wdt_en = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.dom_rst_n !== '0 || bus.rst_cause !== 2'b10) begin
            n_err++;
            $display("FAIL wdt_expire: busy=%b dom=%b cause=%b, want 1/000/10",
                     bus.busy, bus.dom_rst_n, bus.rst_cause);
        end
        run_seq(SEQ_LEN, 2'b10, -1);
    endtask

    task automatic test_wdt_kick();
        logic saw_busy = 1'b0;
        bus.wdt_load = 16'd10;
        bus.wdt_en   = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.wdt_kick = ((i % 8) == 7);
            tick();
            if (bus.busy !== 1'b0) saw_busy = 1'b1;
        end
        bus.wdt_kick = 1'b0;
        bus.wdt_en   = 1'b0;
        tick();
        n_cmp++;
        if (saw_busy !== 1'b0 || bus.rst_cause !== 2'b10) begin
            n_err++;
            $display("FAIL wdt_kicked: saw_busy=%b cause=%b, want 0/10", saw_busy, bus.rst_cause);
        end
    endtask

    task automatic test_simultaneous();
        bus.wdt_load = 16'd10;
        bus.wdt_en   = 1'b1;
        repeat (10) tick();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        bus.wdt_en     = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.rst_cause !== 2'b01) begin
            n_err++;
            $display("FAIL simul_sw_wdt: busy=%b cause=%b, want 1/01", bus.busy, bus.rst_cause);
        end
        run_seq(SEQ_LEN, 2'b01, -1);
    endtask

    task automatic test_kick_on_expiry();
        bus.wdt_load = 16'd10;
        bus.wdt_en   = 1'b1;
        repeat (10) tick();
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL kick_expiry: busy=%b, want 0", bus.busy);
        end
        // A full reload means another 10 quiet edges, then expiry on the 11th.
        repeat (10) tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL kick_reload: busy=%b, want 0", bus.busy);
        end
        tick();
        bus.wdt_en = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.rst_cause !== 2'b10) begin
            n_err++;
            $display("FAIL kick_then_expire: busy=%b cause=%b, want 1/10", bus.busy, bus.rst_cause);
        end
    endtask

    task automatic test_async_mid_release();
        logic [1:0] want;
`ifdef RST_SEQ_CAUSE_STICKY_EN
        want = 2'b10;
`else
        want = 2'b00;
`endif
        run_seq(60, 2'b10, -1);
        #2;
        int_rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.dom_rst_n !== '0 || bus.busy !== 1'b1 || bus.rst_done !== 1'b0 || bus.rst_cause !== want) begin
            n_err++;
            $display("FAIL async_mid: dom=%b busy=%b done=%b cause=%b, want 000/1/0/%b",
                     bus.dom_rst_n, bus.busy, bus.rst_done, bus.rst_cause, want);
        end
        repeat (3) tick();
        int_rst = 1'b1;
        // Mid-sequence software request must be ignored.
        run_seq(SEQ_LEN, want, 55);
    endtask

    initial begin
        bus.sw_rst_req = 1'b0;
        bus.wdt_en     = 1'b0;
        bus.wdt_kick   = 1'b0;
        bus.wdt_load   = 16'd10;
        test_reset();
        test_power_on();
        test_sw_reset();
        test_wdt_expiry();
        test_wdt_kick();
        test_simultaneous();
        test_kick_on_expiry();
        run_seq(SEQ_LEN - 20, 2'b10, -1);
        int_rst = 1'b0;
        tick();
        int_rst = 1'b1;
        bus.sw_rst_req = 1'b0;
        // Recreate a watchdog cause, then reset asynchronously mid-release.
        run_seq(SEQ_LEN, 2'b00, -1);
        bus.wdt_load = 16'd10;
        bus.wdt_en   = 1'b1;
        repeat (11) tick();
        bus.wdt_en = 1'b0;
        test_async_mid_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
